// File: rtl/player_bullet_ctrl_pkg.sv
// player_bullet_ctrl_pkg: shared game constants, coordinate type and bullet FSM encoding.
package player_bullet_ctrl_pkg;

    localparam int COORD_W      = 10;
    localparam int SCREEN_H     = 480;
    localparam int COOL_W       = 8;
    localparam int DEF_SPEED    = 8;
    localparam int DEF_X_OFFSET = 20;
    localparam int DEF_SPAWN_DY = 10;
    localparam int DEF_Y_MIN    = 0;
    localparam int DEF_COOLDOWN = 6;

    typedef logic [COORD_W-1:0] coord_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FLY  = 2'd1,
        ST_COOL = 2'd2
    } bullet_state_e;

endpackage

// File: rtl/player_bullet_ctrl_btn_sync_edge.sv
// btn_sync_edge: 2-flop synchronizer for an async button with a registered rising-edge pulse.
module btn_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic btn_i,
    output logic pulse_o
);
    logic s1_q, s2_q, prev_q, pulse_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            prev_q  <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            s1_q    <= btn_i;
            s2_q    <= s1_q;
            prev_q  <= s2_q;
            pulse_q <= s2_q & ~prev_q;
        end
    end

    assign pulse_o = pulse_q;

endmodule

// File: rtl/player_bullet_ctrl.sv
// player_bullet_ctrl: spawns, moves and retires the player's single bullet.
// Motion advances once per frame tick; a cooldown gates the next shot.
module player_bullet_ctrl
    import player_bullet_ctrl_pkg::*;
#(
    parameter int SPEED    = DEF_SPEED,
    parameter int X_OFFSET = DEF_X_OFFSET,
    parameter int SPAWN_DY = DEF_SPAWN_DY,
    parameter int Y_MIN    = DEF_Y_MIN,
    parameter int COOLDOWN = DEF_COOLDOWN
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               frame_tick,
    input  logic               fire,
    input  logic [COORD_W-1:0] p_x,
    input  logic [COORD_W-1:0] p_y,
    input  logic               hit,
    output logic [COORD_W-1:0] b_x,
    output logic [COORD_W-1:0] b_y,
    output logic               mybullet_en,
    output logic [7:0]         shots
);
    localparam coord_t              SPD        = coord_t'(SPEED);
    localparam coord_t              XOFF       = coord_t'(X_OFFSET);
    localparam coord_t              SDY        = coord_t'(SPAWN_DY);
    localparam coord_t              Y_TOP      = coord_t'(Y_MIN);
    localparam coord_t              SPAWN_LIM  = coord_t'(Y_MIN + SPAWN_DY);
    localparam coord_t              RETIRE_LIM = coord_t'(Y_MIN + SPEED);
    localparam logic [COOL_W-1:0]   COOL_INIT  = COOL_W'(COOLDOWN);

    bullet_state_e       state_q;
    coord_t              b_x_q, b_y_q;
    logic                en_q;
    logic [7:0]          shots_q;
    logic [COOL_W-1:0]   cool_q;
    logic                fire_pulse;

    btn_sync_edge u_fire (
        .clk     (clk),
        .rst     (rst),
        .btn_i   (fire),
        .pulse_o (fire_pulse)
    );

    // Boundary checks compare before subtracting so y never wraps below Y_MIN.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            b_x_q   <= '0;
            b_y_q   <= '0;
            en_q    <= 1'b0;
            shots_q <= '0;
            cool_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: if (fire_pulse) begin
                    state_q <= ST_FLY;
                    b_x_q   <= p_x + XOFF;
                    b_y_q   <= (p_y < SPAWN_LIM) ? Y_TOP : p_y - SDY;
                    en_q    <= 1'b1;
                    shots_q <= shots_q + 8'd1;
                end
                ST_FLY: if (hit || (frame_tick && b_y_q < RETIRE_LIM)) begin
                    state_q <= ST_COOL;
                    en_q    <= 1'b0;
                    cool_q  <= COOL_INIT;
                end else if (frame_tick) begin
                    b_y_q <= b_y_q - SPD;
                end
                ST_COOL: if (cool_q == '0) begin
                    state_q <= ST_IDLE;
                end else if (frame_tick) begin
                    cool_q <= cool_q - COOL_W'(1);
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign b_x         = b_x_q;
    assign b_y         = b_y_q;
    assign mybullet_en = en_q;
    assign shots       = shots_q;

endmodule

// File: tb/tb_player_bullet_ctrl.sv
// tb_player_bullet_ctrl: directed checks of launch, flight, cooldown, wrap and async reset.
module tb_player_bullet_ctrl;
    logic       clk = 1'b0, rst = 1'b1, frame_tick = 1'b0, fire = 1'b0, hit = 1'b0;
    logic [9:0] p_x = 10'd100, p_y = 10'd400;
    logic [9:0] b_x, b_y, b_x0, b_y0;
    logic       en, en0;
    logic [7:0] shots, shots0;
    int         total = 0, bad = 0;

    always #5 clk = ~clk;

    player_bullet_ctrl dut (
        .clk(clk), .rst(rst), .frame_tick(frame_tick), .fire(fire), .p_x(p_x), .p_y(p_y),
        .hit(hit), .b_x(b_x), .b_y(b_y), .mybullet_en(en), .shots(shots)
    );

    player_bullet_ctrl #(.COOLDOWN(0)) dut0 (
        .clk(clk), .rst(rst), .frame_tick(frame_tick), .fire(fire), .p_x(p_x), .p_y(p_y),
        .hit(hit), .b_x(b_x0), .b_y(b_y0), .mybullet_en(en0), .shots(shots0)
    );

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic ftick();
        frame_tick = 1'b1;
        cyc(1);
        frame_tick = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        #1;
        chk("rst_en", en, 0);
        chk("rst_bx", b_x, 0);
        chk("rst_by", b_y, 0);
        chk("rst_shots", shots, 0);
        cyc(2);
        rst = 1'b0;

        fire = 1'b1;
        cyc(3);
        chk("lat_pre", en, 0);
        cyc(1);
        chk("launch_en", en, 1);
        chk("launch_bx", b_x, 120);
        chk("launch_by", b_y, 390);
        chk("launch_shots", shots, 1);
        cyc(46);
        chk("held_shots", shots, 1);
        fire = 1'b0;

        repeat (48) ftick();
        chk("fly_by6", b_y, 6);
        chk("fly_en", en, 1);
        ftick();
        chk("top_en", en, 0);
        chk("top_by", b_y, 6);

        repeat (2) ftick();
        fire = 1'b1;
        cyc(5);
        chk("cool_fire_en", en, 0);
        chk("cool_fire_shots", shots, 1);
        fire = 1'b0;
        cyc(3);
        repeat (3) ftick();
        fire = 1'b1;
        cyc(2);
        ftick();
        cyc(1);
        chk("exit_fire_en", en, 0);
        chk("exit_fire_shots", shots, 1);
        fire = 1'b0;
        cyc(3);
        fire = 1'b1;
        cyc(4);
        chk("idle_fire_en", en, 1);
        chk("idle_fire_shots", shots, 2);

        fire = 1'b0;
        cyc(3);
        fire = 1'b1;
        cyc(5);
        chk("fly_fire_shots", shots, 2);
        chk("fly_fire_by", b_y, 390);
        fire = 1'b0;

        hit = 1'b1;
        frame_tick = 1'b1;
        cyc(1);
        hit = 1'b0;
        frame_tick = 1'b0;
        chk("hit_en", en, 0);
        chk("hit_by", b_y, 390);
        repeat (5) ftick();
        fire = 1'b1;
        cyc(4);
        chk("cool5_en", en, 0);
        fire = 1'b0;
        cyc(3);
        ftick();
        cyc(1);
        fire = 1'b1;
        cyc(4);
        chk("cool6_en", en, 1);
        chk("cool6_shots", shots, 3);

        fire = 1'b0;
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        p_x = 10'd1010;
        p_y = 10'd5;
        for (int i = 0; i < 256; i++) begin
            fire = 1'b1;
            cyc(4);
            fire = 1'b0;
            if (i == 0) begin
                chk("wrapx_bx", b_x, 6);
                chk("clampy_by", b_y, 0);
                chk("clampy_en", en, 1);
                ftick();
                chk("clamp_ret_en", en, 0);
                chk("clamp_ret_by", b_y, 0);
            end else begin
                hit = 1'b1;
                cyc(1);
                hit = 1'b0;
            end
            if (i == 254) chk("shots_255", shots, 255);
            repeat (6) ftick();
            cyc(1);
        end
        chk("shots_wrap", shots, 0);

        p_x = 10'd100;
        p_y = 10'd400;
        fire = 1'b1;
        cyc(4);
        chk("cd0_launch", en0, 1);
        fire = 1'b0;
        cyc(3);
        fire = 1'b1;
        cyc(1);
        hit = 1'b1;
        cyc(1);
        hit = 1'b0;
        chk("cd0_hit_en", en0, 0);
        cyc(1);
        chk("cd0_idle_en", en0, 0);
        cyc(1);
        chk("cd0_relaunch", en0, 1);
        chk("cd0_shots", shots0, 2);

        fire = 1'b0;
        repeat (6) ftick();
        cyc(1);
        fire = 1'b1;
        cyc(4);
        chk("pre_rst_en", en, 1);
        chk("pre_rst_shots", shots, 2);
        repeat (2) ftick();
        #3;
        rst = 1'b1;
        #1;
        chk("arst_en", en, 0);
        chk("arst_bx", b_x, 0);
        chk("arst_by", b_y, 0);
        chk("arst_shots", shots, 0);
        cyc(1);
        rst = 1'b0;
        fire = 1'b0;
        cyc(3);
        fire = 1'b1;
        cyc(4);
        chk("post_rst_en", en, 1);
        chk("post_rst_shots", shots, 1);
        chk("post_rst_bx", b_x, 120);
        chk("post_rst_by", b_y, 390);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/player_bullet_ctrl.md
# player_bullet_ctrl

Spawns, moves and retires the player's single on-screen bullet. Sits directly upstream of the enemy hit/boom judge: its bullet position and enable drive that block's bullet inputs, and it retires the bullet on the judge's hit pulse. It runs at the system clock and advances bullet motion once per frame tick.

## Interface
- SPEED, 8: pixels the bullet rises per frame tick.
- X_OFFSET, 20: horizontal offset from player x to bullet spawn x.
- SPAWN_DY, 10: spawn y = p_y − SPAWN_DY.
- Y_MIN, 0: top boundary; the bullet retires rather than cross it.
- COOLDOWN, 6: frame ticks after retirement before the next shot is accepted (0 allowed).
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- frame_tick  in  1  one-cycle pulse per video frame
- fire  in  1  raw fire button, asynchronous, level
- p_x  in  10  player ship x
- p_y  in  10  player ship y
- hit  in  1  one-cycle pulse from the collision judge: bullet consumed
- b_x  out  10  bullet x
- b_y  out  10  bullet y
- mybullet_en  out  1  bullet alive
- shots  out  8  count of bullets fired, wraps 255→0

## Operation
- States: IDLE (no bullet, ready), FLY (bullet alive), COOL (waiting out the cooldown).
- fire passes a 2-flop synchronizer, then a rising-edge detector. A held button fires once only.
- IDLE + fire edge → FLY:
  - b_x ← p_x + X_OFFSET, truncated to 10 bits.
  - b_y ← p_y − SPAWN_DY. If p_y < Y_MIN + SPAWN_DY, b_y ← Y_MIN.
  - mybullet_en ← 1; shots increments.
- FLY + hit → COOL, mybullet_en ← 0. Hit has priority over a same-cycle frame_tick.
- FLY + frame_tick, no hit:
  - If b_y < Y_MIN + SPEED → COOL, mybullet_en ← 0, b_y unchanged. This prevents the unsigned wrap.
  - Else b_y ← b_y − SPEED.
- b_x is constant during flight.
- Entering COOL loads cool_cnt ← COOLDOWN. Each frame_tick in COOL decrements it. At cool_cnt == 0 → IDLE.
- COOLDOWN = 0 returns to IDLE on the next clk.
- Fire edges in FLY or COOL are discarded, not queued. An edge in the same cycle COOL exits to IDLE is also discarded.
- hit outside FLY is ignored.
- b_x and b_y hold their last values while mybullet_en = 0. Consumers must gate on mybullet_en.

## Timing
- Reset values:
  - state IDLE; mybullet_en 0; b_x 0; b_y 0; shots 0.
  - cool_cnt 0; synchronizer and edge flops 0.
- fire rise to the first sampled sync flop: mybullet_en rises 3 clk later (2 sync stages + 1 edge/launch register).
- hit at edge N → mybullet_en 0 after edge N. The judge therefore sees at most one further cycle with the bullet enabled.
- All outputs are registered; no combinational input→output path.
- Arithmetic is unsigned 10-bit. Compare before subtracting, never after.
- rst mid-flight kills the bullet immediately (asynchronous). shots returns to 0.

## Structure
- Shared game package:
  - coordinate width 10, screen height 480;
  - state encoding IDLE/FLY/COOL (2-bit enum);
  - default SPEED, X_OFFSET, SPAWN_DY.
  - The judge block uses the same width constant.
- One sub-module, btn_sync_edge: 2-flop synchronizer plus rising-edge pulse, async reset. It is reused for other buttons.
- The FSM, cooldown counter and shot counter live in the top module.

## Test plan
- Reset then fire high at 1 cycle, held 50 cycles, p_x=100, p_y=400 → single launch: b_x=120, b_y=390, en=1, shots=1. No second launch while held.
- Flight from b_y=390, SPEED=8:
  - 48 ticks → b_y=6;
  - next tick → en=0 with b_y=6 (no wrap to 1022);
  - COOL for 6 ticks, then IDLE.
- hit pulse while FLY, coincident with frame_tick → en=0 next cycle, b_y not decremented, state COOL. cool_cnt expires after exactly 6 ticks.
- Fire edges during FLY and during COOL, including the COOL→IDLE cycle → no launch, shots unchanged. A fresh edge in IDLE launches.
- 256 complete shots → shots wraps to 0. COOLDOWN=0 variant: relaunch possible 1 clk after retirement.
- rst asserted mid-flight, asynchronous between clock edges → en=0, b_x=b_y=0, shots=0 immediately. Normal launch after release.
